// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the alu_32 control code and operand selects, and raises exceptions.
module mips_multicycle_control #(
    parameter int unsigned CONTROL_SIGNAL_SIZE  = 4,
    parameter logic [1:0]  EXCEPTION_VECTOR_SEL = 2'b11
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [5:0]                     opcode,
    input  logic [5:0]                     funct,
    input  logic                           alu_zero,
    input  logic                           alu_err_overflow,
    input  logic                           alu_err_invalid_control,
    output logic [CONTROL_SIGNAL_SIZE-1:0] alu_control,
    output logic                           alu_src_a,
    output logic [1:0]                     alu_src_b,
    output logic                           iord,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic                           ir_write,
    output logic                           reg_write,
    output logic                           reg_dst,
    output logic                           mem_to_reg,
    output logic                           pc_en,
    output logic [1:0]                     pc_source,
    output logic                           epc_write,
    output logic [1:0]                     cause,
    output logic [3:0]                     state
);

    localparam int unsigned CW = CONTROL_SIGNAL_SIZE;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_EXCEPTION = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [CW-1:0] ALU_AND  = CW'(4'h0);
    localparam logic [CW-1:0] ALU_OR   = CW'(4'h1);
    localparam logic [CW-1:0] ALU_ADD  = CW'(4'h2);
    localparam logic [CW-1:0] ALU_ADDU = CW'(4'h3);
    localparam logic [CW-1:0] ALU_SUB  = CW'(4'h6);
    localparam logic [CW-1:0] ALU_SLT  = CW'(4'h7);
    localparam logic [CW-1:0] ALU_NOR  = CW'(4'hC);

    localparam logic [1:0] CAUSE_RI    = 2'd1;
    localparam logic [1:0] CAUSE_OVF   = 2'd2;
    localparam logic [1:0] CAUSE_FAULT = 2'd3;

    state_t     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       alu_used;
    logic       funct_ok;
    logic       funct_traps;

    // Supported R-type functs and the subset that traps on signed overflow
    always_comb begin
        funct_ok    = 1'b0;
        funct_traps = 1'b0;
        case (funct)
            FN_ADD, FN_SUB:                          begin funct_ok = 1'b1; funct_traps = 1'b1; end
            FN_ADDU, FN_AND, FN_OR, FN_NOR, FN_SLT:  funct_ok = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        cause_d     = cause_q;
        alu_used    = 1'b0;
        alu_control = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_en       = 1'b0;
        pc_source   = 2'd0;
        epc_write   = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_used  = 1'b1;
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'd1;
                pc_en     = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_used  = 1'b1;
                alu_src_b = 2'd3;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_R_EXEC;
                        end else begin
                            state_d = S_EXCEPTION;
                            cause_d = CAUSE_RI;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d = S_EXCEPTION;
                        cause_d = CAUSE_RI;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_used    = 1'b1;
                alu_src_a   = 1'b1;
                alu_src_b   = 2'd2;
                alu_control = ALU_ADDU;
                state_d     = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_used  = 1'b1;
                alu_src_a = 1'b1;
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_ADDU: alu_control = ALU_ADDU;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_NOR:  alu_control = ALU_NOR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
                if (alu_err_overflow && funct_traps) begin
                    state_d = S_EXCEPTION;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_used    = 1'b1;
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = 2'd1;
                pc_en       = alu_zero;
            end
            S_JUMP: begin
                pc_source = 2'd2;
                pc_en     = 1'b1;
            end
            S_ADDI_EXEC: begin
                alu_used  = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (alu_err_overflow) begin
                    state_d = S_EXCEPTION;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_ADDI_WB;
                end
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            S_EXCEPTION: begin
                epc_write = 1'b1;
                pc_source = EXCEPTION_VECTOR_SEL;
                pc_en     = 1'b1;
            end
            default: ;
        endcase

        // An ALU fault outranks every other next-state decision, including overflow
        if (alu_used && alu_err_invalid_control) begin
            state_d = S_EXCEPTION;
            cause_d = CAUSE_FAULT;
        end

        // Keep the datapath quiet for as long as reset is held
        if (!reset_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            pc_en     = 1'b0;
            epc_write = 1'b0;
        end
    end

    assign cause = cause_q;
    assign state = state_q;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multicycle MIPS control FSM. It is the initiator side of the alu_32 interface: it drives the 4-bit ALU control code and the operand-select lines. It consumes zero, err_overflow and err_invalid_control to sequence fetch, decode, execute, memory and writeback. It also raises overflow and reserved-instruction exceptions, and sits between the instruction register and the datapath muxes and enables.

Parameters:
CONTROL_SIGNAL_SIZE, 4, width of alu_control; matches alu_32
EXCEPTION_VECTOR_SEL, 2'b11, pc_source value selecting the exception vector

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
funct  input  6  IR[5:0]
alu_zero  input  1  alu_32 zero
alu_err_overflow  input  1  alu_32 err_overflow
alu_err_invalid_control  input  1  alu_32 err_invalid_control
alu_control  output  4  0x0 AND, 0x1 OR, 0x2 ADD, 0x3 ADDU, 0x6 SUB, 0x7 SLT, 0xC NOR
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  0=reg B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
iord  output  1  memory address: 0=PC, 1=ALUOut
mem_read / mem_write / ir_write  output  1 each  datapath enables
reg_write / reg_dst / mem_to_reg  output  1 each  register-file controls
pc_en  output  1  PC load enable (includes taken branch)
pc_source  output  2  0=ALU, 1=ALUOut, 2=jump target, 3=exception vector
epc_write  output  1  capture PC-4 into EPC
cause  output  2  0 none, 1 reserved instruction, 2 overflow, 3 ALU fault
state  output  4  current state, for debug

Behaviour:
- Registered state only; all outputs are decoded combinationally from state plus opcode/funct. Default for every enable is 0 and default alu_control is 0x2.
- Reset (reset_n low at a clock edge):
  - state <= FETCH, cause <= 0.
  - While reset_n is low, every enable output is forced to 0, in any state, including mid-instruction.
- States (encoding given in brackets):
  - FETCH(0): mem_read, ir_write, iord=0, src_a=0, src_b=1, ADD, pc_source=0, pc_en. Next: DECODE.
  - DECODE(1): src_a=0, src_b=3, ADD (branch target into ALUOut). Next by opcode:
    - 0x00 → R_EXEC if funct ∈ {0x20 add, 0x21 addu, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt}, else EXCEPTION with cause=1.
    - 0x23 lw / 0x2B sw → MEM_ADDR.
    - 0x04 beq → BRANCH.
    - 0x02 j → JUMP.
    - 0x08 addi → ADDI_EXEC.
    - any other opcode → EXCEPTION with cause=1.
  - MEM_ADDR(2): src_a=1, src_b=2, ADDU. Next: MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ(3): mem_read, iord=1. Next: MEM_WB.
  - MEM_WB(4): reg_write, reg_dst=0, mem_to_reg=1. Next: FETCH.
  - MEM_WRITE(5): mem_write, iord=1. Next: FETCH.
  - R_EXEC(6): src_a=1, src_b=0, alu_control from the funct map (add→0x2, addu→0x3, sub→0x6, and→0x0, or→0x1, nor→0xC, slt→0x7). Next: EXCEPTION with cause=2 if alu_err_overflow and funct ∈ {add, sub}; otherwise R_WB.
  - R_WB(7): reg_write, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - BRANCH(8): src_a=1, src_b=0, SUB, pc_source=1, pc_en = alu_zero, sampled combinationally in the same cycle. Next: FETCH.
  - JUMP(9): pc_source=2, pc_en. Next: FETCH.
  - ADDI_EXEC(10): src_a=1, src_b=2, ADD. Next: EXCEPTION with cause=2 if alu_err_overflow, else ADDI_WB.
  - ADDI_WB(11): reg_write, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - EXCEPTION(12): epc_write, pc_source=EXCEPTION_VECTOR_SEL, pc_en. Next: FETCH.
- ALU fault: alu_err_invalid_control sampled high in any state that drives the ALU → next state EXCEPTION with cause=3. This fault takes priority over overflow.
- cause is registered on entry to EXCEPTION and holds until the next exception or reset.
- Trapping instructions never reach a writeback state, so reg_write is never asserted for them. addu and lw/sw address overflow never trap.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, exception path 1 extra cycle after detection.
- Unused state codes 13–15 → FETCH on the next edge with all enables 0.

Test Plan:
1. Reset, then lw (opcode 0x23): state sequence 0,1,2,3,4,0; mem_read high in states 0 and 3; reg_write high only in state 4 with mem_to_reg=1; alu_control=0x3 in state 2.
2. add (opcode 0x00, funct 0x20) with alu_err_overflow=1 in R_EXEC: next state 12, cause=2, epc_write=1, pc_source=3, reg_write never asserted. Same stimulus with funct 0x21: proceeds to state 7 with reg_write=1.
3. beq (opcode 0x04) with alu_zero=1 in BRANCH: pc_en=1, pc_source=1, alu_control=0x6. Repeat with alu_zero=0: pc_en=0. Both return to FETCH.
4. Opcode 0x3F, then R-type with funct 0x00: each goes DECODE→EXCEPTION with cause=1 and no reg_write or mem_write.
5. reset_n driven low during MEM_WRITE: all enables 0 in that cycle; after the edge state=0 and cause=0; a fresh sw completes in 4 cycles.
6. alu_err_invalid_control=1 during ADDI_EXEC with alu_err_overflow=1: state 12 with cause=3.
